// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants for the pipelined RISC-V core.
// No logic of its own; zero latency.
// No flow control here; consumers own their handshakes.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  // A fetch target is usable only when it is word aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} fetch entries, with flush and fill count.
// Push to head visibility: 1 cycle; head is read combinationally (zero-latency pop).
// Push and pop may coincide at any level, including full; flush wins over both.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a push into a full FIFO is safe then.
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer and count next-state; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are never observed while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_stage_pipe.sv
// Decoupled instruction fetch: PC, imem request issue, response buffering to decode.
// Request issues from the current PC; response reaches id_valid 1 cycle later.
// Credit-limited issue (in-flight + buffered <= FIFO_DEPTH); decode stalls via id_ready.
module if_stage_pipe #(
  parameter int unsigned     XLEN         = core_pkg::XLEN,
  parameter int unsigned     ILEN         = core_pkg::ILEN,
  parameter int unsigned     FIFO_DEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            misaligned_err
);

  import core_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = XLEN + ILEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            err_q, err_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_head;
  logic            fifo_push;
  logic            fifo_pop;

  logic            credit_ok;
  logic            req_hs;
  logic            redirect_eff;
  logic            rsp_drop;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  // Every issued request owns a buffer slot until decode pops it, so a
  // returning response can never find the FIFO full.
  assign credit_ok    = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign req_hs       = imem_req_valid && imem_req_ready;
  assign redirect_eff = redirect_valid && (state_q != BOOT);
  assign rsp_drop     = (drop_q != '0);

  // A response arriving with a redirect belongs to the old stream and is dropped.
  assign fifo_push = imem_rsp_valid && !rsp_drop && !redirect_eff && (state_q == RUN);
  assign fifo_pop  = id_valid && id_ready;

  assign imem_req_valid = (state_q == RUN) && credit_ok;
  assign imem_req_addr  = pc_q;
  assign misaligned_err = err_q;

  assign head_pc    = fifo_head[FW-1:ILEN];
  assign head_instr = fifo_head[ILEN-1:0];

  // Head outputs read as zero while the buffer is empty.
  assign id_valid    = !fifo_empty;
  assign id_instr    = id_valid ? head_instr : '0;
  assign id_pc       = id_valid ? head_pc : '0;
  assign id_pc_plus4 = id_valid ? (head_pc + XLEN'(PC_INC)) : '0;

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (fifo_push),
    .push_data_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_eff),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  // Next-state for the FSM, PC, response-PC tag and the credit/drop counters.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    err_d      = err_q;
    drop_d     = drop_q;
    inflight_d = inflight_q;

    if (req_hs)         inflight_d = inflight_d + CW'(1);
    if (imem_rsp_valid) inflight_d = inflight_d - CW'(1);

    if (req_hs) pc_d = pc_q + XLEN'(PC_INC);

    if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CW'(1);

    // Responses return in order and requests walk the PC by 4, so the PC of
    // the next kept response is simply tracked by counting kept responses.
    if (fifo_push) rsp_pc_d = rsp_pc_q + XLEN'(PC_INC);

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, ERR: begin
        if (redirect_eff) begin
          // Everything still outstanding after this edge is stale, including
          // a request accepted right now; a response arriving now is dropped.
          drop_d   = inflight_d;
          pc_d     = redirect_target;
          rsp_pc_d = redirect_target;
          if (is_aligned(redirect_target[1:0])) begin
            state_d = RUN;
            err_d   = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State registers; reset returns to BOOT at the reset vector with nothing outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      inflight_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe with a latency-configurable in-order imem model.
// Expected PCs/instructions are hand-derived; instr image is 0xC0DE_0000 | addr[15:0].
// Checks sampled on the falling edge; inputs driven away from the rising edge.
module tb_if_stage_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misaligned_err;

  int passed = 0;
  int total  = 0;

  int          mdl_lat = 1;
  int          cyc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] issued[$];

  if_stage_pipe #(
    .XLEN         (32),
    .ILEN         (32),
    .FIFO_DEPTH   (2),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .misaligned_err  (misaligned_err)
  );

  always #5 clk = ~clk;

  // In-order imem: accept on handshake, answer mdl_lat cycles later, one per cycle.
  always @(posedge clk) begin
    logic [31:0] a;
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
      issued.delete();
    end else begin
      if (imem_rsp_valid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + mdl_lat);
        issued.push_back(imem_req_addr);
      end
    end
    cyc++;
    #1;
    if (reset && q_addr.size() > 0 && q_due[0] <= cyc) begin
      a = q_addr[0];
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hC0DE_0000 | {16'h0000, a[15:0]};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait (bounded) for the next decode handshake and check the delivered entry.
  task automatic expect_instr(input string tag, input logic [31:0] pc, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (id_valid && id_ready) begin
        got = 1'b1;
        chk({tag, ".pc"}, id_pc, pc);
        chk({tag, ".instr"}, id_instr, 32'hC0DE_0000 | {16'h0000, pc[15:0]});
        chk({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
      end
      @(negedge clk);
    end
    if (!got) begin
      total++;
      $error("FAIL %s.timeout: no decode handshake within %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset(input int lat);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mdl_lat = lat;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    @(negedge clk);
    redirect_valid  = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          bad;
    bit          hit;

    // Reset values.
    @(negedge clk);
    chk("rst.req_valid", imem_req_valid, 0);
    chk("rst.id_valid", id_valid, 0);
    chk("rst.err", misaligned_err, 0);
    chk("rst.addr", imem_req_addr, 32'h0);
    chk("rst.instr", id_instr, 0);
    chk("rst.pc", id_pc, 0);
    chk("rst.pc4", id_pc_plus4, 0);

    // 1: linear fetch at latency 1; a redirect during BOOT is ignored.
    do_reset(1);
    id_ready = 1'b1;
    reset = 1'b1;
    redirect(32'h0000_0500);
    expect_instr("t1.a", 32'h0, 20);
    expect_instr("t1.b", 32'h4, 20);
    expect_instr("t1.c", 32'h8, 20);
    expect_instr("t1.d", 32'hC, 20);
    for (int i = 0; i < 4; i++) begin
      v = (issued.size() > i) ? issued[i] : 32'hDEAD_BEEF;
      chk($sformatf("t1.issued%0d", i), v, 32'(4 * i));
    end

    // 2: decode stalled, credit limits issue to FIFO_DEPTH requests.
    do_reset(1);
    id_ready = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2.issued", issued.size(), 2);
    chk("t2.req_valid", imem_req_valid, 0);
    chk("t2.id_valid", id_valid, 1);
    id_ready = 1'b1;
    expect_instr("t2.a", 32'h0, 5);
    expect_instr("t2.b", 32'h4, 5);
    expect_instr("t2.c", 32'h8, 20);

    // 3: latency 3, redirect while two fetches are outstanding.
    do_reset(3);
    id_ready = 1'b1;
    reset = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (q_addr.size() == 2 && !imem_rsp_valid) hit = 1'b1;
      else @(negedge clk);
    end
    chk("t3.two_inflight", hit, 1);
    redirect(32'h0000_0100);
    chk("t3.flushed", id_valid, 0);
    expect_instr("t3.a", 32'h100, 30);
    expect_instr("t3.b", 32'h104, 30);

    // 4: redirect coincident with a response and a request handshake.
    do_reset(1);
    id_ready = 1'b1;
    reset = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (imem_req_valid && imem_rsp_valid) hit = 1'b1;
      else @(negedge clk);
    end
    chk("t4.coincide", hit, 1);
    redirect(32'h0000_0300);
    chk("t4.flushed", id_valid, 0);
    expect_instr("t4.a", 32'h300, 20);
    expect_instr("t4.b", 32'h304, 20);

    // 5: misaligned redirect parks the stage until an aligned redirect.
    redirect(32'h0000_0102);
    chk("t5.err_set", misaligned_err, 1);
    chk("t5.addr", imem_req_addr, 32'h0000_0102);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t5.quiet", bad, 0);
    chk("t5.err_held", misaligned_err, 1);
    redirect(32'h0000_0200);
    chk("t5.err_clr", misaligned_err, 0);
    expect_instr("t5.a", 32'h200, 20);
    expect_instr("t5.b", 32'h204, 20);

    // 6: PC wraps past the top of the address space.
    redirect(32'hFFFF_FFFC);
    expect_instr("t6.a", 32'hFFFF_FFFC, 20);
    expect_instr("t6.b", 32'h0000_0000, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
